// File: rtl/seq_gen_tx.sv
// seq_gen_tx: serial frame transmitter with repeats; SEQ_GEN_TX_PREAMBLE_EN adds a 1,0,0,0 preamble per frame
module seq_gen_tx #(
    parameter int WIDTH = 8,
    parameter int LENW  = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic [LENW-1:0]  len,
    input  logic [2:0]       rep,
    output logic             dout,
    output logic             dvalid,
    output logic             busy,
    output logic             done
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, PRE, SHIFT, GAP} state_t;
`ifdef SEQ_GEN_TX_PREAMBLE_EN
    localparam state_t FIRST = PRE;
    logic [1:0] pre_q, pre_d;
`else
    localparam state_t FIRST = SHIFT;
`endif
    state_t           state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [IW-1:0]    idx_q, idx_d, last_q, last_d;
    logic [2:0]       rep_q, rep_d;
    logic             dout_q, dout_d, dvalid_q, dvalid_d, busy_q, busy_d, done_q, done_d;
    logic [LENW-1:0]  len_eff;
    assign len_eff = (len == '0 || len > LENW'(WIDTH)) ? LENW'(WIDTH) : len;
    // next state, latched frame parameters and the output values for the coming cycle
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        last_d  = last_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
`ifdef SEQ_GEN_TX_PREAMBLE_EN
        pre_d   = '0;
`endif
        case (state_q)
            IDLE: if (start) begin
                word_d  = data;
                last_d  = IW'(len_eff - LENW'(1));
                idx_d   = IW'(len_eff - LENW'(1));
                rep_d   = rep;
                state_d = FIRST;
            end
`ifdef SEQ_GEN_TX_PREAMBLE_EN
            PRE: begin
                pre_d   = pre_q + 2'd1;
                state_d = (pre_q == 2'd3) ? SHIFT : PRE;
            end
`endif
            SHIFT: begin
                idx_d   = idx_q - IW'(1);
                state_d = (idx_q != '0) ? SHIFT : (rep_q != '0) ? GAP : IDLE;
            end
            GAP: begin
                rep_d   = rep_q - 3'd1;
                idx_d   = last_q;
                state_d = FIRST;
            end
            default: state_d = IDLE;
        endcase
        done_d   = state_q == SHIFT && idx_q == '0 && rep_q == '0;
        busy_d   = state_d != IDLE;
        dvalid_d = state_d == SHIFT || state_d == PRE;
        dout_d   = state_d == SHIFT && word_d[idx_d];
`ifdef SEQ_GEN_TX_PREAMBLE_EN
        if (state_d == PRE) dout_d = pre_d == 2'd0;
`endif
    end
    // state and output registers with synchronous clear
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= IDLE;
            word_q   <= '0;
            last_q   <= '0;
            idx_q    <= '0;
            rep_q    <= '0;
            dout_q   <= 1'b0;
            dvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SEQ_GEN_TX_PREAMBLE_EN
            pre_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            last_q   <= last_d;
            idx_q    <= idx_d;
            rep_q    <= rep_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SEQ_GEN_TX_PREAMBLE_EN
            pre_q    <= pre_d;
`endif
        end
    end
    assign dout   = dout_q;
    assign dvalid = dvalid_q;
    assign busy   = busy_q;
    assign done   = done_q;
endmodule

// File: tb/tb_seq_gen_tx.sv
// tb_seq_gen_tx: directed stimulus against a frame-queue model of seq_gen_tx
module tb_seq_gen_tx;
    localparam int WIDTH = 8;
    localparam int LENW  = 4;
`ifdef SEQ_GEN_TX_PREAMBLE_EN
    localparam int P = 4;
`else
    localparam int P = 0;
`endif
    logic             clk = 1'b0;
    logic             clr = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] data = '0;
    logic [LENW-1:0]  len = '0;
    logic [2:0]       rep = '0;
    logic             dout, dvalid, busy, done;
    int               n_cmp = 0;
    int               n_bad = 0;
    typedef struct packed {logic busy; logic dvalid; logic dout; logic done;} o_t;
    o_t               q[$];
    o_t               cur = '0;
    logic [63:0]      vbits;
    int               nvalid, nbusy, ndone;

    always #5 clk = ~clk;

    seq_gen_tx #(.WIDTH(WIDTH), .LENW(LENW)) dut (
        .clk(clk), .clr(clr), .start(start), .data(data), .len(len), .rep(rep),
        .dout(dout), .dvalid(dvalid), .busy(busy), .done(done)
    );

    function automatic void build(input logic [WIDTH-1:0] d, input int l_in, input int r_in);
        int l;
        l = (l_in == 0 || l_in > WIDTH) ? WIDTH : l_in;
        for (int r = 0; r <= r_in; r++) begin
            for (int i = 0; i < P; i++) q.push_back(o_t'({2'b11, (i == 0), 1'b0}));
            for (int b = l - 1; b >= 0; b--) q.push_back(o_t'({2'b11, d[b], 1'b0}));
            if (r < r_in) q.push_back(o_t'(4'b1000));
        end
        q.push_back(o_t'(4'b0001));
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (clr) begin
            q.delete();
            cur = '0;
        end else begin
            if (!cur.busy && start) build(data, int'(len), int'(rep));
            cur = (q.size() > 0) ? q.pop_front() : o_t'(4'b0000);
        end
        @(negedge clk);
        check($sformatf("cycle@%0t {busy,dvalid,dout,done}", $time), 64'({busy, dvalid, dout, done}), 64'(cur));
        if (dvalid) begin
            vbits = {vbits[62:0], dout};
            nvalid++;
        end
        if (busy) nbusy++;
        if (done) ndone++;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic clear_log();
        vbits = '0;
        nvalid = 0;
        nbusy = 0;
        ndone = 0;
    endtask

    task automatic go(input logic [WIDTH-1:0] d, input logic [LENW-1:0] l, input logic [2:0] r);
        clear_log();
        data = d;
        len = l;
        rep = r;
        start = 1'b1;
        cycle();
        start = 1'b0;
        run(70);
    endtask

    initial begin
        clear_log();
        run(3);
        check("reset outputs", 64'({busy, dvalid, dout, done}), 64'h0);
        clr = 1'b0;
        run(2);
        go(8'hB5, 4'd0, 3'd0);
        check("b5 bits", vbits, (P == 4) ? 64'h8B5 : 64'hB5);
        check("b5 busy", 64'(nbusy), (P == 4) ? 64'd12 : 64'd8);
        check("b5 done", 64'(ndone), 64'd1);
        go(8'h03, 4'd2, 3'd1);
        check("rep1 bits", vbits, (P == 4) ? 64'h8E3 : 64'hF);
        check("rep1 busy", 64'(nbusy), (P == 4) ? 64'd13 : 64'd5);
        check("rep1 done", 64'(ndone), 64'd1);
        go(8'hA1, 4'd1, 3'd0);
        check("len1 bits", vbits, (P == 4) ? 64'h11 : 64'h1);
        check("len1 busy", 64'(nbusy), (P == 4) ? 64'd5 : 64'd1);
        go(8'h3C, 4'd12, 3'd0);
        check("len>W bits", vbits, (P == 4) ? 64'h83C : 64'h3C);
        check("len>W count", 64'(nvalid), (P == 4) ? 64'd12 : 64'd8);
        go(8'h02, 4'd2, 3'd7);
        check("rep7 bits", vbits, (P == 4) ? 64'({8{6'b100010}}) : 64'({8{2'b10}}));
        check("rep7 busy", 64'(nbusy), (P == 4) ? 64'd55 : 64'd23);
        check("rep7 done", 64'(ndone), 64'd1);
        clear_log();
        data = 8'h05;
        len = 4'd3;
        rep = 3'd0;
        start = 1'b1;
        run(12);
        start = 1'b0;
        run(20);
        check("held start bits", vbits, (P == 4) ? 64'h22C5 : 64'h16D);
        check("held start done", 64'(ndone), (P == 4) ? 64'd2 : 64'd3);
        clear_log();
        data = 8'hB5;
        len = 4'd0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        run(2);
        clr = 1'b1;
        cycle();
        check("clr mid-frame outputs", 64'({busy, dvalid, dout, done}), 64'h0);
        clr = 1'b0;
        run(15);
        check("clr mid-frame done", 64'(ndone), 64'd0);
        check("clr mid-frame busy", 64'(nbusy), 64'd3);
        clear_log();
        data = 8'h96;
        len = 4'd0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        data = 8'h00;
        run(3);
        data = 8'hFF;
        len = 4'd2;
        rep = 3'd3;
        start = 1'b1;
        cycle();
        start = 1'b0;
        run(30);
        check("busy start bits", vbits, (P == 4) ? 64'h896 : 64'h96);
        check("busy start done", 64'(ndone), 64'd1);
        clear_log();
        rep = 3'd0;
        clr = 1'b1;
        start = 1'b1;
        cycle();
        check("clr over start", 64'({busy, dvalid, dout, done}), 64'h0);
        clr = 1'b0;
        start = 1'b0;
        run(5);
        check("clr over start busy", 64'(nbusy), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
